// File: rtl/ram_loader.sv
// ram_loader: streams words into RAM64 from a fixed base address, then reads
// the same range back through the RAM's combinational port and compares
// checksums. Reports busy/done/error to the boot sequencer.
module ram_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ram_load,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_VERIFY,
        ST_DONE
    } state_t;

    // Full RAM depth; the index is one bit wider so a full-depth load fits.
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Requests longer than the RAM are clamped to the RAM depth.
    function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] req);
        return (req > DEPTH) ? DEPTH : req;
    endfunction

    state_t                state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   index;
    logic [ADDR_WIDTH:0]   idx_next;
    logic [ADDR_WIDTH:0]   len_req;
    logic [DATA_WIDTH-1:0] write_sum;
    logic [DATA_WIDTH-1:0] read_sum;
    logic [DATA_WIDTH-1:0] read_total;

    assign len_req    = clamp_len(length);
    assign idx_next   = index + IDX_ONE;
    // ram_out only ever reaches registers through this sum.
    assign read_total = read_sum + ram_out;

    // RAM-side controls are combinational so each write lands on the edge of
    // its own handshake. The address wraps naturally by truncation.
    assign in_ready    = (state == ST_WRITE);
    assign ram_load    = in_ready & in_valid;
    assign ram_address = BASE + index[ADDR_WIDTH-1:0];
    assign ram_data_in = in_data;

    // Load/verify sequencer with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            index     <= '0;
            write_sum <= '0;
            read_sum  <= '0;
            checksum  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len_q     <= len_req;
                        index     <= '0;
                        write_sum <= '0;
                        read_sum  <= '0;
                        error     <= 1'b0;
                        if (len_req == '0) begin
                            // Empty load completes at once with a zero checksum.
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            checksum <= '0;
                        end else begin
                            state <= ST_WRITE;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (in_valid) begin
                        write_sum <= write_sum + in_data;
                        if (idx_next == len_q) begin
                            index <= '0;
                            state <= ST_VERIFY;
                        end else begin
                            index <= idx_next;
                        end
                    end
                end
                ST_VERIFY: begin
                    read_sum <= read_total;
                    if (idx_next == len_q) begin
                        // Last readback word: close out the load.
                        index    <= '0;
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        error    <= (read_total != write_sum);
                        checksum <= write_sum;
                    end else begin
                        index <= idx_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader: directed loads against a RAM model, with a
// cycle-by-cycle reference model of the expected handshake/status behaviour.
module tb_ram_loader;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   length = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          force_zero = 1'b0;

    logic          in_ready, ram_load, busy, done, error;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_out, checksum;

    logic          in_ready_b, ram_load_b, busy_b, done_b, error_b;
    logic [AW-1:0] ram_address_b;
    logic [DW-1:0] ram_data_in_b, ram_out_b, checksum_b;

    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] mem_b [64];
    logic [AW-1:0] wa_b [$];
    int            wr_count_a = 0;
    int            cyc = 0;
    int            cyc_e0 = 0;

    int            n_checks = 0;
    int            n_err = 0;

    logic [DW-1:0] wbuf [0:127];
    bit            vpat [0:7];

    always #5 clk = ~clk;

    ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE(6'd0)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .length(length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_load(ram_load), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_out(ram_out), .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE(6'd62)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .length(length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .ram_load(ram_load_b), .ram_address(ram_address_b), .ram_data_in(ram_data_in_b),
        .ram_out(ram_out_b), .busy(busy_b), .done(done_b), .error(error_b), .checksum(checksum_b)
    );

    // RAM64 models: synchronous write, combinational read.
    assign ram_out   = force_zero ? '0 : mem_a[ram_address];
    assign ram_out_b = mem_b[ram_address_b];

    always @(posedge clk) begin
        if (ram_load) begin
            mem_a[ram_address] <= ram_data_in;
            wr_count_a <= wr_count_a + 1;
        end
        if (ram_load_b) begin
            mem_b[ram_address_b] <= ram_data_in_b;
            wa_b.push_back(ram_address_b);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: counts of words accepted and verify cycles.
    bit            m_active = 1'b0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;
    int            m_len = 0;
    int            m_wr = 0;
    int            m_vf = 0;
    logic [DW-1:0] m_sum = '0;
    logic [DW-1:0] m_rsum = '0;
    logic [DW-1:0] m_cks = '0;

    // Compare on every falling edge, then advance the model to the next rising edge.
    initial begin
        bit exp_ready;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_error", 32'(error), 32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd0);
                check("rst_ram_load", 32'(ram_load), 32'd0);
                check("rst_checksum", 32'(checksum), 32'd0);
                check("rst_address", 32'(ram_address), 32'd0);
                m_active = 1'b0; m_done = 1'b0; m_err = 1'b0;
                m_len = 0; m_wr = 0; m_vf = 0;
                m_sum = '0; m_rsum = '0; m_cks = '0;
            end else begin
                exp_ready = m_active && (m_wr < m_len);
                check("in_ready", 32'(in_ready), 32'(exp_ready));
                check("ram_load", 32'(ram_load), 32'(exp_ready && in_valid));
                check("busy", 32'(busy), 32'(m_active));
                check("done", 32'(done), 32'(m_done));
                if (exp_ready && in_valid) begin
                    check("wr_addr", 32'(ram_address), 32'(m_wr % 64));
                    check("wr_data", 32'(ram_data_in), 32'(in_data));
                end
                if (m_active && !exp_ready)
                    check("rd_addr", 32'(ram_address), 32'(m_vf % 64));
                if (m_done) begin
                    check("error", 32'(error), 32'(m_err));
                    check("checksum", 32'(checksum), 32'(m_cks));
                end
                if (!m_active) begin
                    if (start) begin
                        m_len = (length > 7'd64) ? 64 : int'(length);
                        m_wr = 0; m_vf = 0; m_sum = '0; m_rsum = '0;
                        m_err = 1'b0;
                        if (m_len == 0) begin
                            m_done = 1'b1;
                            m_cks = '0;
                        end else begin
                            m_done = 1'b0;
                            m_active = 1'b1;
                        end
                    end
                end else if (m_wr < m_len) begin
                    if (in_valid) begin
                        m_sum += in_data;
                        m_wr++;
                    end
                end else begin
                    m_rsum += ram_out;
                    m_vf++;
                    if (m_vf == m_len) begin
                        m_active = 1'b0;
                        m_done = 1'b1;
                        m_cks = m_sum;
                        m_err = (m_rsum != m_sum);
                    end
                end
            end
        end
    end

    task automatic start_load(input logic [AW:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        length = l;
        @(posedge clk); #1;
        start = 1'b0;
        cyc_e0 = cyc;
    endtask

    task automatic feed(input int n, input bit use_pat);
        int i = 0;
        int p = 0;
        while (i < n && p < 300) begin
            in_valid = use_pat ? ((p < 8) ? vpat[p] : 1'b1) : 1'b1;
            in_data = wbuf[i];
            @(posedge clk); #1;
            if (in_valid) i++;
            p++;
        end
        in_valid = 1'b0;
        if (i < n) check("feed_timeout", 32'(i), 32'(n));
    endtask

    task automatic wait_done(input int budget, output int lat);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
        lat = cyc - cyc_e0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int w0;
        int b0;
        int bad;
        int exp_wa [4];
        exp_wa = '{62, 63, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_addr_b", 32'(ram_address_b), 32'd62);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        reset_n = 1'b1;

        // Basic load of four words.
        wbuf[0] = 16'h0001; wbuf[1] = 16'h0002; wbuf[2] = 16'h0003; wbuf[3] = 16'h0004;
        w0 = wr_count_a;
        start_load(7'd4);
        feed(4, 1'b0);
        wait_done(40, lat);
        check("basic_latency", 32'(lat), 32'd8);
        check("basic_checksum", 32'(checksum), 32'h000A);
        check("basic_error", 32'(error), 32'd0);
        check("basic_writes", 32'(wr_count_a - w0), 32'd4);
        for (int k = 0; k < 4; k++)
            check("basic_mem", 32'(mem_a[k]), 32'(k + 1));

        // Stalled stream, restarted straight from DONE.
        wbuf[0] = 16'h0010; wbuf[1] = 16'h0020; wbuf[2] = 16'h0030;
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        w0 = wr_count_a;
        start_load(7'd3);
        feed(3, 1'b1);
        wait_done(40, lat);
        check("stall_latency", 32'(lat), 32'd9);
        check("stall_writes", 32'(wr_count_a - w0), 32'd3);
        check("stall_checksum", 32'(checksum), 32'h0060);

        // Address wrap (second instance) and checksum overflow.
        for (int k = 0; k < 4; k++) wbuf[k] = 16'hFFFF;
        b0 = wa_b.size();
        start_load(7'd4);
        feed(4, 1'b0);
        wait_done(40, lat);
        check("wrap_count", 32'(wa_b.size() - b0), 32'd4);
        if (wa_b.size() - b0 == 4) begin
            for (int k = 0; k < 4; k++)
                check("wrap_addr", 32'(wa_b[b0 + k]), 32'(exp_wa[k]));
        end
        check("wrap_done_b", 32'(done_b), 32'd1);
        check("wrap_checksum_b", 32'(checksum_b), 32'hFFFC);
        check("wrap_error_b", 32'(error_b), 32'd0);
        check("wrap_checksum", 32'(checksum), 32'hFFFC);

        // Corrupted readback on the second verify cycle.
        wbuf[0] = 16'h1234; wbuf[1] = 16'h0001;
        start_load(7'd2);
        feed(2, 1'b0);
        @(posedge clk); #1;
        force_zero = 1'b1;
        @(posedge clk); #1;
        force_zero = 1'b0;
        wait_done(10, lat);
        check("corrupt_latency", 32'(lat), 32'd4);
        check("corrupt_error", 32'(error), 32'd1);
        check("corrupt_checksum", 32'(checksum), 32'h1235);

        // Zero-length load.
        w0 = wr_count_a;
        start_load(7'd0);
        wait_done(5, lat);
        check("zero_latency", 32'(lat), 32'd0);
        check("zero_writes", 32'(wr_count_a - w0), 32'd0);
        check("zero_checksum", 32'(checksum), 32'd0);
        check("zero_error", 32'(error), 32'd0);

        // Oversize request clamps to the full RAM depth.
        for (int k = 0; k < 128; k++) wbuf[k] = 16'(16'h0100 + k);
        w0 = wr_count_a;
        start_load(7'd127);
        feed(64, 1'b0);
        wait_done(200, lat);
        check("clamp_latency", 32'(lat), 32'd128);
        check("clamp_writes", 32'(wr_count_a - w0), 32'd64);
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (mem_a[k] !== 16'(16'h0100 + k)) bad++;
        check("clamp_mem", 32'(bad), 32'd0);
        check("clamp_checksum", 32'(checksum), 32'h47E0);

        // Reset in the middle of a five-word load.
        for (int k = 0; k < 5; k++) wbuf[k] = 16'(k + 1);
        start_load(7'd5);
        feed(2, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_checksum", 32'(checksum), 32'd0);
        check("midrst_address", 32'(ram_address), 32'd0);
        check("midrst_address_b", 32'(ram_address_b), 32'd62);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        start_load(7'd5);
        feed(5, 1'b0);
        wait_done(40, lat);
        check("fresh_latency", 32'(lat), 32'd10);
        check("fresh_checksum", 32'(checksum), 32'h000F);
        check("fresh_error", 32'(error), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Boot/program loader that sits directly upstream of the RAM64 memory. It accepts a stream of 16-bit words over a valid/ready handshake and writes them into consecutive RAM addresses starting at a fixed base. It then reads the same range back through the RAM's combinational read port and compares a 16-bit checksum of the read-back data against the checksum of what was written. It reports busy, done and error to the sequencer that brings the computer out of boot.

## Interface
- ADDR_WIDTH, 6, RAM address width; RAM64 uses 6.
- DATA_WIDTH, 16, word width.
- BASE, 0, first RAM address written; ADDR_WIDTH bits.
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE and DONE.
- length  input  ADDR_WIDTH+1  number of words to load; latched on start.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_WIDTH  upstream word.
- in_ready  output  1  loader accepts a word this cycle.
- ram_load  output  1  drives the RAM `load` input.
- ram_address  output  ADDR_WIDTH  drives the RAM `address` input.
- ram_data_in  output  DATA_WIDTH  drives the RAM `data_in` input.
- ram_out  input  DATA_WIDTH  RAM combinational read data.
- busy  output  1  high in WRITE or VERIFY.
- done  output  1  level; high in DONE.
- error  output  1  level; checksum mismatch from the last load, valid while done=1.
- checksum  output  DATA_WIDTH  sum of words written in the last load.

## Operation
- **States:** IDLE, WRITE, VERIFY, DONE.
- **IDLE or DONE, start=1:**
  - Latch `len = min(length, 2^ADDR_WIDTH)`.
  - Clear the index, write sum and read sum.
  - Clear done and error.
  - Go to WRITE, or go directly to DONE if len=0. A len=0 load finishes with checksum=0 and error=0.
- **WRITE:**
  - in_ready=1.
  - A handshake occurs when in_valid=1 in the same cycle.
  - On a handshake: ram_load=1, ram_address=(BASE+index) mod 2^ADDR_WIDTH, ram_data_in=in_data. The RAM captures the word on the same edge.
  - On a handshake: index increments, and write sum += in_data, modulo 2^DATA_WIDTH.
  - When a handshake makes index equal to len, the index resets to 0 and the state goes to VERIFY.
  - in_valid=0 stalls the load indefinitely with no RAM write.
- **VERIFY:**
  - ram_load=0 and ram_address=(BASE+index) mod 2^ADDR_WIDTH.
  - Every cycle, read sum += ram_out and index increments.
  - After len cycles, go to DONE and set error = (read sum + final ram_out) != write sum.
- **DONE:** done=1, and checksum holds the write sum. Stay in DONE until start.
- **start while busy:** ignored.
- **Address wrap:** the address wraps modulo 2^ADDR_WIDTH. With BASE=60 and len=8, addresses 60..63 are followed by 0..3.
- **In IDLE, VERIFY and DONE:** in_ready=0 and ram_load=0. ram_data_in follows in_data; it is don't-care when ram_load=0.
- **Reset, asserted at any time including mid-load:**
  - State goes to IDLE.
  - busy, done, error, in_ready and ram_load go to 0.
  - checksum, index and both sums go to 0.
  - ram_address goes to BASE.
  - RAM contents already written are not touched.

## Timing
- ram_load, ram_address, ram_data_in and in_ready are combinational from state, index and in_valid/in_data. This is required so each write lands on the edge of its handshake.
- Start sampled at edge E0: WRITE begins in the cycle after E0.
- With in_valid held high, the last word is written at edge E_len.
- VERIFY occupies the next len cycles.
- done=1 and busy=0 from the cycle after the last verify cycle, i.e. 2·len+1 cycles after E0.
- No combinational path from ram_out to any output. The error register is updated only on the DONE transition.
- Back-to-back loads: start asserted during DONE restarts on the next edge.

## Test plan
- **Basic load:** BASE=0, length=4, words 0x0001, 0x0002, 0x0003, 0x0004 with in_valid held high.
  - RAM addresses 0..3 hold those words.
  - checksum=0x000A, error=0, done=1 nine cycles after start.
- **Stalled stream:** length=3, in_valid toggling 1,0,0,1,0,1.
  - Exactly 3 RAM writes, each in a handshake cycle only.
  - busy stays high throughout; done=1 after 3 verify cycles.
- **Wrap and checksum overflow:** BASE=62, length=4, words 0xFFFF ×4.
  - Writes go to addresses 62, 63, 0, 1.
  - checksum=0xFFFC, error=0.
- **Corrupt readback:** length=2, words 0x1234, 0x0001. Force ram_out on the second verify cycle to 0x0000.
  - done=1, error=1, checksum=0x1235.
- **Edge lengths:**
  - length=0: done=1 one cycle after start with no RAM write.
  - length=127: clamped to 64 words, addresses 0..63 all written.
- **Reset mid-load:** assert reset_n=0 after 2 of 5 words.
  - All outputs go to 0 immediately, ram_address goes to BASE.
  - A fresh start completes normally.
